// File: rtl/rect_draw_ctrl_if.sv
// rect_draw_ctrl_if: strobe, coordinate and pixel bundle between a host and the rectangle-draw controller
interface rect_draw_ctrl_if #(
  parameter int X_W  = 8,
  parameter int Y_W  = 7,
  parameter int SZ_W = 4
);
  logic            load;
  logic            draw;
  logic [X_W-1:0]  coord_in;
  logic [SZ_W-1:0] width_in;
  logic [SZ_W-1:0] height_in;
  logic            outline;
  logic [X_W-1:0]  x_out;
  logic [Y_W-1:0]  y_out;
  logic            plot;
  logic            busy;
  logic            done;
  logic [2:0]      current_state;
  modport master (
    output load, draw, coord_in, width_in, height_in, outline,
    input  x_out, y_out, plot, busy, done, current_state
  );
  modport slave (
    input  load, draw, coord_in, width_in, height_in, outline,
    output x_out, y_out, plot, busy, done, current_state
  );
endinterface

// File: rtl/rect_draw_ctrl.sv
// rect_draw_ctrl: loads an x/y origin, then raster-scans a clipped filled or outlined rectangle one pixel per clock
module rect_draw_ctrl #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int SZ_W  = 4,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input logic            clk,
  input logic            resetn,
  rect_draw_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    LOAD_X    = 3'd0,
    WAIT_X    = 3'd1,
    LOAD_Y    = 3'd2,
    WAIT_Y    = 3'd3,
    WAIT_DRAW = 3'd4,
    DRAW      = 3'd5,
    DONE      = 3'd6
  } state_t;
  state_t          state_q, state_d;
  logic [X_W-1:0]  x_org_q, x_org_d;
  logic [Y_W-1:0]  y_org_q, y_org_d;
  logic [SZ_W-1:0] w_q, w_d, h_q, h_d, cx_q, cx_d, cy_q, cy_d;
  logic            outline_q, outline_d;
  logic [SZ_W-1:0] w_m1, h_m1;
  logic            row_end, last;
  logic [X_W:0]    x_sum;
  logic [Y_W:0]    y_sum;
  logic            visible, edge_px;
  assign w_m1    = w_q - SZ_W'(1);
  assign h_m1    = h_q - SZ_W'(1);
  assign row_end = cx_q == w_m1;
  assign last    = row_end && cy_q == h_m1;
  always_comb begin
    state_d   = state_q;
    x_org_d   = x_org_q;
    y_org_d   = y_org_q;
    w_d       = w_q;
    h_d       = h_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    outline_d = outline_q;
    case (state_q)
      LOAD_X: begin
        x_org_d = bus.coord_in;
        state_d = bus.load ? WAIT_X : LOAD_X;
      end
      WAIT_X: state_d = bus.load ? WAIT_X : LOAD_Y;
      LOAD_Y: begin
        y_org_d = bus.coord_in[Y_W-1:0];
        state_d = bus.load ? WAIT_Y : LOAD_Y;
      end
      WAIT_Y: state_d = bus.load ? WAIT_Y : WAIT_DRAW;
      WAIT_DRAW: begin
        if (bus.draw) begin
          w_d       = bus.width_in;
          h_d       = bus.height_in;
          outline_d = bus.outline;
          cx_d      = '0;
          cy_d      = '0;
          state_d   = (bus.width_in == '0 || bus.height_in == '0) ? DONE : DRAW;
        end
      end
      DRAW: begin
        cx_d    = row_end ? '0 : cx_q + SZ_W'(1);
        cy_d    = row_end ? cy_q + SZ_W'(1) : cy_q;
        state_d = last ? DONE : DRAW;
      end
      default: state_d = LOAD_X;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= LOAD_X;
      x_org_q   <= '0;
      y_org_q   <= '0;
      w_q       <= '0;
      h_q       <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      outline_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_org_q   <= x_org_d;
      y_org_q   <= y_org_d;
      w_q       <= w_d;
      h_q       <= h_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      outline_q <= outline_d;
    end
  end
  assign x_sum   = (X_W+1)'(x_org_q) + (X_W+1)'(cx_q);
  assign y_sum   = (Y_W+1)'(y_org_q) + (Y_W+1)'(cy_q);
  assign visible = x_sum < (X_W+1)'(SCR_W) && y_sum < (Y_W+1)'(SCR_H);
  assign edge_px = !outline_q || cx_q == '0 || row_end || cy_q == '0 || cy_q == h_m1;
  assign bus.x_out         = x_sum[X_W-1:0];
  assign bus.y_out         = y_sum[Y_W-1:0];
  assign bus.plot          = state_q == DRAW && visible && edge_px;
  assign bus.busy          = state_q == DRAW || state_q == DONE;
  assign bus.done          = state_q == DONE;
  assign bus.current_state = state_q;
endmodule

// File: tb/tb_rect_draw_ctrl.sv
// tb_rect_draw_ctrl: scenario and randomized checks of rect_draw_ctrl against a pixel-list model
module tb_rect_draw_ctrl;
  localparam int X_W = 8, Y_W = 7, SZ_W = 4;
  logic clk = 1'b0;
  logic resetn;
  int checks = 0;
  int passes = 0;
  always #5 clk = ~clk;
  rect_draw_ctrl_if #(.X_W(X_W), .Y_W(Y_W), .SZ_W(SZ_W)) bus ();
  rect_draw_ctrl #(.X_W(X_W), .Y_W(Y_W), .SZ_W(SZ_W), .SCR_W(160), .SCR_H(120)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );
  task automatic load_coords(input int x, input int y);
    bus.coord_in = X_W'(x);
    bus.load = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.current_state !== 3'd1) $display("FAIL load_wait_x state=%0d exp=1", bus.current_state);
    else passes++;
    bus.load = 1'b0;
    bus.coord_in = X_W'($urandom);
    @(negedge clk);
    bus.coord_in = X_W'(y);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    bus.coord_in = X_W'($urandom);
    @(negedge clk);
    checks++;
    if (bus.current_state !== 3'd4) $display("FAIL load_wait_draw state=%0d exp=4", bus.current_state);
    else passes++;
  endtask
  task automatic do_draw(input int x, input int y, input int w, input int h, input bit ol,
                         input bit hold, input bit with_load, output int nplot);
    logic [20:0] got, exp;
    bit p;
    bus.width_in = SZ_W'(w);
    bus.height_in = SZ_W'(h);
    bus.outline = ol;
    bus.draw = 1'b1;
    bus.load = with_load;
    @(negedge clk);
    bus.load = 1'b0;
    bus.draw = hold;
    bus.width_in = SZ_W'($urandom);
    bus.height_in = SZ_W'($urandom);
    bus.outline = 1'($urandom);
    nplot = 0;
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        p = (x + cx < 160) && (y + cy < 120) &&
            (!ol || cx == 0 || cx == w - 1 || cy == 0 || cy == h - 1);
        if (p) nplot++;
        exp = {3'd5, 1'b1, 1'b0, p, X_W'((x + cx) % 256), Y_W'((y + cy) % 128)};
        got = {bus.current_state, bus.busy, bus.done, bus.plot, bus.x_out, bus.y_out};
        checks++;
        if (got !== exp) $display("FAIL pixel(%0d,%0d) got=%h exp=%h", cx, cy, got, exp);
        else passes++;
        @(negedge clk);
      end
    end
    checks++;
    if ({bus.current_state, bus.busy, bus.done, bus.plot} !== {3'd6, 3'b110})
      $display("FAIL done_cycle st=%0d busy=%b done=%b plot=%b exp 6/1/1/0",
               bus.current_state, bus.busy, bus.done, bus.plot);
    else passes++;
    @(negedge clk);
    checks++;
    if ({bus.current_state, bus.busy, bus.done} !== {3'd0, 2'b00})
      $display("FAIL after_done st=%0d busy=%b done=%b exp 0/0/0", bus.current_state, bus.busy, bus.done);
    else passes++;
    if (hold) begin
      @(negedge clk);
      checks++;
      if (bus.current_state !== 3'd0) $display("FAIL draw_hold_no_retrigger state=%0d exp=0", bus.current_state);
      else passes++;
      bus.draw = 1'b0;
    end
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    bus.load = 1'b0;
    bus.draw = 1'b0;
    bus.coord_in = 8'd99;
    bus.width_in = '0;
    bus.height_in = '0;
    bus.outline = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.current_state, bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out} !== '0)
      $display("FAIL reset_outputs st=%0d plot=%b busy=%b done=%b x=%0d y=%0d exp all 0",
               bus.current_state, bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out);
    else passes++;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.current_state !== 3'd0) $display("FAIL reset_release state=%0d exp=0", bus.current_state);
    else passes++;
  endtask
  task automatic test_scenario(input string name, input int x, input int y, input int w,
                               input int h, input bit ol, input int exp_plots);
    int n;
    load_coords(x, y);
    do_draw(x, y, w, h, ol, 1'b0, 1'b0, n);
    checks++;
    if (n !== exp_plots) $display("FAIL %s plots=%0d exp=%0d", name, n, exp_plots);
    else passes++;
  endtask
  task automatic test_reset_mid_draw();
    int n;
    load_coords(30, 40);
    bus.width_in = 4'd8;
    bus.height_in = 4'd8;
    bus.outline = 1'b0;
    bus.draw = 1'b1;
    @(negedge clk);
    bus.draw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.current_state, bus.plot, bus.x_out, bus.y_out} !== {3'd5, 1'b1, X_W'(30 + i), Y_W'(40)})
        $display("FAIL mid_pixel%0d st=%0d plot=%b x=%0d y=%0d", i, bus.current_state, bus.plot, bus.x_out, bus.y_out);
      else passes++;
      @(negedge clk);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.current_state, bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out} !== '0)
      $display("FAIL reset_mid_draw st=%0d plot=%b busy=%b x=%0d y=%0d exp all 0",
               bus.current_state, bus.plot, bus.busy, bus.x_out, bus.y_out);
    else passes++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    load_coords(5, 6);
    do_draw(5, 6, 2, 2, 1'b0, 1'b0, 1'b0, n);
    checks++;
    if (n !== 4) $display("FAIL post_reset_draw plots=%0d exp=4", n);
    else passes++;
  endtask
  task automatic test_strobe_hold();
    int n;
    bus.coord_in = 8'd77;
    bus.load = 1'b1;
    @(negedge clk);
    for (int i = 1; i < 10; i++) begin
      bus.coord_in = X_W'($urandom);
      checks++;
      if (bus.current_state !== 3'd1) $display("FAIL hold_wait_x cyc%0d state=%0d exp=1", i, bus.current_state);
      else passes++;
      @(negedge clk);
    end
    bus.load = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.current_state !== 3'd2) $display("FAIL hold_release state=%0d exp=2", bus.current_state);
    else passes++;
    bus.coord_in = 8'd50;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
    do_draw(77, 50, 1, 1, 1'b0, 1'b1, 1'b0, n);
  endtask
  task automatic test_random();
    int x, y, w, h, n;
    bit ol;
    for (int t = 0; t < 12; t++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 127));
      w = int'($urandom_range(0, 15));
      h = int'($urandom_range(0, 15));
      ol = 1'($urandom);
      load_coords(x, y);
      do_draw(x, y, w, h, ol, 1'($urandom), 1'($urandom), n);
    end
  endtask
  initial begin
    test_reset();
    test_scenario("fill", 10, 20, 4, 4, 1'b0, 16);
    test_scenario("outline", 0, 0, 4, 3, 1'b1, 10);
    test_scenario("clip", 158, 118, 4, 4, 1'b0, 4);
    test_scenario("zero_size", 12, 34, 0, 5, 1'b0, 0);
    test_reset_mid_draw();
    test_strobe_hold();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
